// File: rtl/truth_table_sweep.sv
// truth_table_sweep
//   Walks a 4-input function under test through all 16 input vectors.
//   Each vector is held for HOLD cycles. On the last cycle of each hold
//   window the response f is captured into tt_out and compared against
//   the golden table.
//
// Parameters
//   HOLD            cycles each vector is held (1..255)
// Ports
//   clk             sole clock, rising edge
//   rst             synchronous active-high reset
//   start           sweep request, sampled only in IDLE
//   expected[15:0]  golden truth table, bit i = required f for vector i
//   f               response of the function under test
//   a,b,c,d         stimulus, {a,b,c,d} = vector index (a = MSB)
//   busy            high while sweeping
//   done            one-cycle pulse at sweep end
//   tt_out[15:0]    captured truth table
//   mismatch_count  vectors where f != expected, 0..16
//   pass            last completed sweep had no mismatches
module truth_table_sweep #(
    parameter int unsigned HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt_out,
    output logic [4:0]  mismatch_count,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] tt_q, tt_d;
    logic [4:0]  mm_q, mm_d;
    logic        pass_q, pass_d;

    logic        last_hold;
    logic        miss;
    logic [4:0]  mm_inc;

    assign last_hold = (hold_q == HOLD_LAST);
    assign miss      = (f != expected[idx_q]);
    // Saturate at 16 so the count can never wrap.
    assign mm_inc    = (miss && (mm_q != 5'd16)) ? mm_q + 5'd1 : mm_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   if (last_hold && (idx_q == 4'd15)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        idx_d  = idx_q;
        hold_d = hold_q;
        tt_d   = tt_q;
        mm_d   = mm_q;
        pass_d = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d  = '0;
                    hold_d = '0;
                    tt_d   = '0;
                    mm_d   = '0;
                    pass_d = 1'b0;
                end
            end
            DRIVE: begin
                if (last_hold) begin
                    tt_d[idx_q] = f;
                    mm_d        = mm_inc;
                    hold_d      = '0;
                    // Index 15 wraps to 0 naturally on the final sample.
                    idx_d       = idx_q + 4'd1;
                    // pass is settled on entry to DONE so it is already
                    // valid while done is high, using the final count.
                    if (idx_q == 4'd15) begin
                        pass_d = (mm_inc == 5'd0);
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            hold_q <= '0;
            tt_q   <= '0;
            mm_q   <= '0;
            pass_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            hold_q <= hold_d;
            tt_q   <= tt_d;
            mm_q   <= mm_d;
            pass_q <= pass_d;
        end
    end

    // Outputs
    always_comb begin
        {a, b, c, d}   = idx_q;
        busy           = (state_q == DRIVE);
        done           = (state_q == DONE);
        tt_out         = tt_q;
        mismatch_count = mm_q;
        pass           = pass_q;
    end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: three instances with HOLD = 2, 1, 3 share
// one clock. The function under test is modelled per instance from a
// selectable behaviour; expected tables come from a per-vector model.
module tb_truth_table_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0]  rst_s, start_s, f_s, a_s, b_s, c_s, d_s, busy_s, done_s, pass_s;
    logic [15:0] exp_s  [3];
    logic [15:0] rtab_s [3];
    logic [15:0] tt_s   [3];
    logic [4:0]  mm_s   [3];
    int          fsel_s [3];

    // 0: stuck-at-0, 1: stuck-at-1, 2: AND4, other: lookup table
    function automatic logic fval(int fs, logic [15:0] rt, logic [3:0] v);
        case (fs)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return &v;
            default: return rt[v];
        endcase
    endfunction

    function automatic int holdof(int u);
        return (u == 0) ? 2 : (u == 1) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : G
        localparam int unsigned HV = (g == 0) ? 2 : (g == 1) ? 1 : 3;
        assign f_s[g] = fval(fsel_s[g], rtab_s[g], {a_s[g], b_s[g], c_s[g], d_s[g]});
        truth_table_sweep #(.HOLD(HV)) dut (
            .clk            (clk),
            .rst            (rst_s[g]),
            .start          (start_s[g]),
            .expected       (exp_s[g]),
            .f              (f_s[g]),
            .a              (a_s[g]),
            .b              (b_s[g]),
            .c              (c_s[g]),
            .d              (d_s[g]),
            .busy           (busy_s[g]),
            .done           (done_s[g]),
            .tt_out         (tt_s[g]),
            .mismatch_count (mm_s[g]),
            .pass           (pass_s[g])
        );
    end

    function automatic logic [3:0] vec(int u);
        return {a_s[u], b_s[u], c_s[u], d_s[u]};
    endfunction

    task automatic chk(string tag, int u, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL u%0d %s observed=%0h expected=%0h", u, tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string tag, int u);
        chk({tag, "_busy"}, u, busy_s[u], 0);
        chk({tag, "_done"}, u, done_s[u], 0);
        chk({tag, "_vec"},  u, vec(u), 0);
        chk({tag, "_tt"},   u, tt_s[u], 0);
        chk({tag, "_mm"},   u, mm_s[u], 0);
        chk({tag, "_pass"}, u, pass_s[u], 0);
    endtask

    task automatic do_reset(int u, logic st);
        rst_s[u]   = 1'b1;
        start_s[u] = st;
        tick();
        tick();
        chk_zero("reset", u);
        rst_s[u]   = 1'b0;
        start_s[u] = 1'b0;
    endtask

    task automatic sweep(int u, int fs, logic [15:0] ex, logic [15:0] rt, bit keep);
        int          h;
        logic [15:0] mtt;
        int          mmm;
        h = holdof(u);
        for (int i = 0; i < 16; i++) mtt[i] = fval(fs, rt, 4'(i));
        mmm = $countones(mtt ^ ex);

        fsel_s[u]  = fs;
        exp_s[u]   = ex;
        rtab_s[u]  = rt;
        start_s[u] = 1'b1;
        tick();
        chk("start_busy", u, busy_s[u], 1);
        chk("start_vec",  u, vec(u), 0);
        chk("start_tt",   u, tt_s[u], 0);
        chk("start_mm",   u, mm_s[u], 0);
        chk("start_pass", u, pass_s[u], 0);
        if (!keep) start_s[u] = 1'b0;

        for (int n = 1; n <= 16 * h; n++) begin
            tick();
            chk("busy", u, busy_s[u], (n < 16 * h) ? 1 : 0);
            chk("done", u, done_s[u], (n == 16 * h) ? 1 : 0);
            chk("vec",  u, vec(u), (n / h) % 16);
            if (n == 16 * h) begin
                chk("done_tt", u, tt_s[u], mtt);
                chk("done_mm", u, mm_s[u], mmm);
            end
        end

        tick();
        chk("idle_busy", u, busy_s[u], 0);
        chk("idle_done", u, done_s[u], 0);
        chk("idle_tt",   u, tt_s[u], mtt);
        chk("idle_mm",   u, mm_s[u], mmm);
        chk("idle_pass", u, pass_s[u], (mmm == 0) ? 1 : 0);

        if (keep) begin
            tick();
            chk("restart_busy", u, busy_s[u], 1);
            chk("restart_done", u, done_s[u], 0);
            chk("restart_tt",   u, tt_s[u], 0);
            chk("restart_mm",   u, mm_s[u], 0);
            start_s[u] = 1'b0;
            do_reset(u, 1'b0);
        end else begin
            for (int n = 0; n < 3; n++) begin
                tick();
                chk("hold_busy", u, busy_s[u], 0);
                chk("hold_tt",   u, tt_s[u], mtt);
                chk("hold_mm",   u, mm_s[u], mmm);
                chk("hold_pass", u, pass_s[u], (mmm == 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int dones;
        int u;
        logic [15:0] rt, ex;

        rst_s   = '1;
        start_s = '0;
        for (int i = 0; i < 3; i++) begin
            exp_s[i]  = '0;
            rtab_s[i] = '0;
            fsel_s[i] = 0;
        end
        tick();
        tick();
        rst_s = '0;

        // Reset with start held high, then no sweep without a new start
        for (int i = 0; i < 3; i++) do_reset(i, 1'b1);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("post_reset_busy", 0, busy_s[0], 0);
            chk("post_reset_vec",  0, vec(0), 0);
        end

        // AND4, HOLD=2
        sweep(0, 2, 16'h8000, 16'h0000, 1'b0);
        // Stuck-at-0
        sweep(0, 0, 16'h8000, 16'h0000, 1'b0);
        // Stuck-at-1 vs all-zero golden, HOLD=1
        sweep(1, 1, 16'h0000, 16'h0000, 1'b0);

        // Mid-sweep reset at idx 7, HOLD=3
        fsel_s[2]  = 1;
        exp_s[2]   = 16'h0000;
        start_s[2] = 1'b1;
        tick();
        start_s[2] = 1'b0;
        for (int n = 1; n <= 21; n++) tick();
        chk("mid_vec", 2, vec(2), 7);
        rst_s[2] = 1'b1;
        tick();
        rst_s[2] = 1'b0;
        chk_zero("mid_reset", 2);
        dones = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (done_s[2] || busy_s[2]) dones++;
        end
        chk("mid_no_activity", 2, dones, 0);

        // start held high through a sweep
        sweep(0, 2, 16'h8000, 16'h0000, 1'b1);

        // Random tables
        for (int r = 0; r < 6; r++) begin
            u  = $urandom_range(0, 2);
            rt = 16'($urandom);
            ex = (r % 2 == 1) ? rt : 16'($urandom);
            sweep(u, 3, ex, rt, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 SHALL provide parameter: HOLD, 4, clock cycles each input vector is held; legal range 1..255.
REQ-002 SHALL provide port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port: start  input  1  sweep request, sampled in IDLE only.
REQ-005 SHALL provide port: expected  input  16  golden truth table; bit i = required f for vector i.
REQ-006 SHALL provide port: f  input  1  response of the 4-input function under test.
REQ-007 SHALL provide ports: a, b, c, d  output  1 each  stimulus to the function under test; {a,b,c,d} = vector index, a = MSB.
REQ-008 SHALL provide port: busy  output  1  high while sweeping.
REQ-009 SHALL provide port: done  output  1  one-cycle pulse at sweep end.
REQ-010 SHALL provide port: tt_out  output  16  captured truth table; bit i = f sampled for vector i.
REQ-011 SHALL provide port: mismatch_count  output  5  number of vectors where f != expected[i], range 0..16.
REQ-012 SHALL provide port: pass  output  1  high when the last completed sweep had mismatch_count == 0.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, DONE.
REQ-014 SHALL drive {a,b,c,d} from a registered 4-bit index idx in every state.
REQ-015 In IDLE with start=1, SHALL move to DRIVE at the next edge, with idx=0, hold counter=0, tt_out=0, mismatch_count=0 and pass=0.
REQ-016 In IDLE with start=0, SHALL remain in IDLE with all outputs held.
REQ-017 In DRIVE, SHALL hold each vector for exactly HOLD cycles, counting the hold counter 0..HOLD-1.
REQ-018 On the DRIVE edge where hold counter == HOLD-1, SHALL write f into tt_out[idx] and increment mismatch_count if f != expected[idx].
REQ-019 On that same edge, if idx < 15, SHALL increment idx, clear the hold counter, and stay in DRIVE.
REQ-020 On that same edge, if idx == 15, SHALL move to DONE and wrap idx to 0.
REQ-021 With HOLD=1, SHALL sample every cycle and change the vector every cycle.
REQ-022 In DONE, SHALL assert done for exactly one cycle, set pass = (mismatch_count == 0), and return to IDLE at the next edge.
REQ-023 SHALL assert busy iff state == DRIVE.
REQ-024 SHALL keep tt_out, mismatch_count and pass stable from DONE until the next accepted start.
REQ-025 SHALL ignore start in DRIVE and DONE, with no restart and no state change.
REQ-026 SHALL accept a start asserted in the IDLE cycle immediately after DONE.
REQ-027 Latency: accepted start at edge k -> first sample at edge k+HOLD, last sample at edge k+16*HOLD, done high in cycle k+16*HOLD+1.
REQ-028 SHALL ensure mismatch_count does not wrap; the maximum value is 16 (5'b10000).

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, idx=0, hold counter=0, {a,b,c,d}=0, busy=0, done=0, tt_out=0, mismatch_count=0, pass=0.
REQ-030 SHALL give rst priority over start and over any in-progress sweep; reset mid-sweep abandons the sweep with no done pulse.
REQ-031 SHALL require start to be re-asserted after reset release before a new sweep begins.

Verification
REQ-032 Reset check: assert rst for 2 cycles, with start=1 during reset -> all outputs 0, busy=0, no sweep after release until start re-pulses.
REQ-033 AND4 check: HOLD=2, f=a&b&c&d, expected=16'h8000 -> tt_out=16'h8000, mismatch_count=0, pass=1, done pulse 33 cycles after the start edge.
REQ-034 Stuck-at-0 check: f tied 0, expected=16'h8000 -> tt_out=0, mismatch_count=1, pass=0.
REQ-035 Full-mismatch and timing check: f tied 1, expected=0, HOLD=1 -> tt_out=16'hFFFF, mismatch_count=16, pass=0, {a,b,c,d} steps 0..15 on consecutive cycles.
REQ-036 Mid-sweep reset check: HOLD=3, rst pulsed while idx=7 -> next cycle IDLE, all outputs 0, no done pulse.
REQ-037 Start-ignore check: start held high throughout a sweep -> exactly one sweep completes, then a second sweep starts in the cycle after DONE, with tt_out cleared at its start.
